// File: rtl/hdmi_i2c_cfg_seq.sv
// HDMI transmitter bring-up sequencer: walks a register table and issues one
// I2C write (addr+W, reg, val) per entry, or a timed delay for reg == 8'hFF.
module hdmi_i2c_cfg_seq #(
    parameter int         CLK_DIV     = 63,
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         NUM_ENTRIES = 32,
    parameter int         IDX_W       = 5,
    parameter int         DELAY_UNIT  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] cfg_addr,
    input  logic [15:0]      cfg_data,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             scl_oe,
    output logic             sda_oe
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int UNIT_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_BYTE, S_STOP, S_WAIT, S_FIN
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [1:0]         qtr, qtr_nxt;
    logic [3:0]         bit_cnt, bit_nxt;
    logic [1:0]         byte_cnt, byte_nxt;
    logic [7:0]         reg_q, reg_nxt;
    logic [7:0]         val_q, val_nxt;
    logic [UNIT_W-1:0]  unit_cnt, unit_nxt;
    logic [7:0]         tick_cnt, tick_nxt;
    logic               nack_q, nack_nxt;
    logic [IDX_W-1:0]   addr_nxt;
    logic               err_nxt;
    logic               advance;
    logic               qtr_end;
    logic               scl_meta, scl_sync, sda_meta, sda_sync;

    function automatic logic [7:0] pick_byte(input logic [1:0] b, input logic [7:0] r,
                                             input logic [7:0] v);
        logic [7:0] res;
        case (b)
            2'd0:    res = {DEV_ADDR, 1'b0};
            2'd1:    res = r;
            default: res = v;
        endcase
        return res;
    endfunction

    function automatic logic scl_drive(input state_t s, input logic [1:0] q);
        return (s == S_BYTE || s == S_STOP) && !q[1];
    endfunction

    // Bit 8 of each byte is the ACK slot, where SDA is always released.
    function automatic logic sda_drive(input state_t s, input logic [1:0] q,
                                       input logic [3:0] b, input logic [7:0] cur);
        logic res;
        case (s)
            S_START: res = q[1];
            S_BYTE:  res = !b[3] && !cur[~b[2:0]];
            S_STOP:  res = (q != 2'd3);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
        end
    end

    assign qtr_end = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        qtr_nxt   = qtr;
        bit_nxt   = bit_cnt;
        byte_nxt  = byte_cnt;
        reg_nxt   = reg_q;
        val_nxt   = val_q;
        unit_nxt  = unit_cnt;
        tick_nxt  = tick_cnt;
        nack_nxt  = nack_q;
        addr_nxt  = cfg_addr;
        err_nxt   = error;
        advance   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    addr_nxt  = '0;
                    err_nxt   = 1'b0;
                    nack_nxt  = 1'b0;
                    div_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (div_cnt == '0) begin
                    div_nxt = DIV_W'(1);
                end else begin
                    reg_nxt  = cfg_data[15:8];
                    val_nxt  = cfg_data[7:0];
                    div_nxt  = '0;
                    qtr_nxt  = '0;
                    bit_nxt  = '0;
                    byte_nxt = '0;
                    unit_nxt = '0;
                    tick_nxt = '0;
                    if (cfg_data[15:8] != 8'hFF)
                        state_nxt = S_START;
                    else if (cfg_data[7:0] == 8'h00)
                        advance = 1'b1;
                    else
                        state_nxt = S_WAIT;
                end
            end
            S_START, S_BYTE, S_STOP: begin
                if (!qtr_end) begin
                    div_nxt = div_cnt + DIV_W'(1);
                end else if (qtr == 2'd2 && !scl_sync) begin
                    div_nxt = div_cnt;
                end else begin
                    div_nxt = '0;
                    qtr_nxt = qtr + 2'd1;
                    if (qtr == 2'd3) begin
                        case (state)
                            S_START: begin
                                state_nxt = S_BYTE;
                                bit_nxt   = '0;
                                byte_nxt  = '0;
                            end
                            S_BYTE: begin
                                if (bit_cnt != 4'd8) begin
                                    bit_nxt = bit_cnt + 4'd1;
                                end else if (sda_sync) begin
                                    nack_nxt  = 1'b1;
                                    err_nxt   = 1'b1;
                                    state_nxt = S_STOP;
                                end else if (byte_cnt == 2'd2) begin
                                    state_nxt = S_STOP;
                                end else begin
                                    byte_nxt = byte_cnt + 2'd1;
                                    bit_nxt  = '0;
                                end
                            end
                            default: advance = 1'b1;
                        endcase
                    end
                end
            end
            S_WAIT: begin
                if (unit_cnt == UNIT_W'(DELAY_UNIT - 1)) begin
                    unit_nxt = '0;
                    if (tick_cnt == val_q - 8'd1)
                        advance = 1'b1;
                    else
                        tick_nxt = tick_cnt + 8'd1;
                end else begin
                    unit_nxt = unit_cnt + UNIT_W'(1);
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // A NACK skips the rest of the table; cfg_addr then names the failing entry.
        if (advance) begin
            if (nack_q || cfg_addr == IDX_W'(NUM_ENTRIES - 1)) begin
                state_nxt = S_FIN;
            end else begin
                addr_nxt  = cfg_addr + IDX_W'(1);
                state_nxt = S_LOAD;
                div_nxt   = '0;
            end
        end
    end

    // Pad and status outputs are registered from next-state values so they
    // track the state exactly without combinational glitches on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            reg_q    <= '0;
            val_q    <= '0;
            unit_cnt <= '0;
            tick_cnt <= '0;
            nack_q   <= 1'b0;
            cfg_addr <= '0;
            error    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            qtr      <= qtr_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
            reg_q    <= reg_nxt;
            val_q    <= val_nxt;
            unit_cnt <= unit_nxt;
            tick_cnt <= tick_nxt;
            nack_q   <= nack_nxt;
            cfg_addr <= addr_nxt;
            error    <= err_nxt;
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_FIN);
            scl_oe   <= scl_drive(state_nxt, qtr_nxt);
            sda_oe   <= sda_drive(state_nxt, qtr_nxt, bit_nxt,
                                  pick_byte(byte_nxt, reg_nxt, val_nxt));
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_cfg_seq.sv
// Bench for hdmi_i2c_cfg_seq: I2C slave model on the open-drain bus plus a
// table-level reference model of bytes, errors, final index and run length.
module tb_hdmi_i2c_cfg_seq;

    localparam int         CD     = 4;
    localparam int         DU     = 10;
    localparam int         NE     = 4;
    localparam int         IW     = 2;
    localparam logic [6:0] DEV    = 7'h39;
    localparam int         BUDGET = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, error;
    logic [IW-1:0] cfg_addr;
    logic [15:0]   cfg_data;
    logic          scl_in, sda_in, scl_oe, sda_oe;

    logic [15:0]   tbl [NE];
    int            n_tests = 0;
    int            n_fail  = 0;

    logic          mon_clr;
    int            nack_txn, nack_byte, stretch_len;

    logic          sl_sda_low, sl_scl_hold;
    logic          ps, pd, s_now, d_now;
    logic [7:0]    sh;
    int            sl_bits, sl_byte, hold_cnt, n_start, n_stop;
    bit            stretched;
    logic [7:0]    rx_bytes[$];

    logic [7:0]    exp_bytes[$];
    int            exp_cyc, exp_txn, exp_addr;
    logic          exp_err;
    int            cyc;

    hdmi_i2c_cfg_seq #(
        .CLK_DIV(CD), .DEV_ADDR(DEV), .NUM_ENTRIES(NE), .IDX_W(IW), .DELAY_UNIT(DU)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done), .error(error),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .scl_in(scl_in), .sda_in(sda_in),
        .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cfg_data <= tbl[cfg_addr];

    assign scl_in = ~(scl_oe | sl_scl_hold);
    assign sda_in = ~(sda_oe | sl_sda_low);

    // Slave samples the wired bus 2 ns after each rising clock edge.
    always begin : i2c_slave
        @(posedge clk);
        #2;
        if (rst || mon_clr) begin
            sl_sda_low = 1'b0; sl_scl_hold = 1'b0; hold_cnt = 0;
            sl_bits = 0; sl_byte = 0; n_start = 0; n_stop = 0; stretched = 1'b0;
            rx_bytes.delete();
            ps = scl_in; pd = sda_in;
        end else begin
            s_now = scl_in; d_now = sda_in;
            if (ps && s_now && pd && !d_now) begin
                n_start++; sl_bits = 0; sl_byte = 0;
            end else if (ps && s_now && !pd && d_now) begin
                n_stop++;
            end
            if (!ps && s_now) begin
                if (sl_bits < 8) sh = {sh[6:0], d_now};
                sl_bits++;
                if (sl_bits == 8) rx_bytes.push_back(sh);
            end else if (ps && !s_now) begin
                if (sl_bits == 8)
                    sl_sda_low = !(nack_txn == n_start - 1 && nack_byte == sl_byte);
                else if (sl_bits == 9) begin
                    sl_sda_low = 1'b0; sl_bits = 0; sl_byte++;
                end
                if (stretch_len > 0 && !stretched && n_start == 1 && sl_byte == 1 && sl_bits == 3) begin
                    stretched = 1'b1; hold_cnt = stretch_len;
                end
            end
            sl_scl_hold = (hold_cnt > 0);
            if (hold_cnt > 0) hold_cnt--;
            ps = s_now; pd = d_now;
        end
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic build_model();
        logic [7:0] r, v;
        logic [7:0] b [3];
        int nb, w;
        bit halt;
        exp_bytes.delete();
        exp_cyc = 1; exp_err = 1'b0; exp_addr = 0; w = 0; halt = 1'b0;
        for (int e = 0; e < NE && !halt; e++) begin
            exp_addr = e;
            r = tbl[e][15:8];
            v = tbl[e][7:0];
            if (r == 8'hFF) begin
                exp_cyc += 2 + int'(v) * DU;
            end else begin
                b[0] = {DEV, 1'b0}; b[1] = r; b[2] = v; nb = 3;
                if (w == nack_txn) begin
                    nb = nack_byte + 1; exp_err = 1'b1; halt = 1'b1;
                end
                for (int k = 0; k < nb; k++) exp_bytes.push_back(b[k]);
                exp_cyc += 2 + (8 + 36 * nb) * CD;
                w++;
            end
        end
        exp_txn = w;
    endtask

    task automatic clear_monitor();
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) mon_clr = 1'b0;
    endtask

    task automatic run_seq(input int poke_at, input int poke_len, input bit poke_done,
                           output int n_cyc);
        int guard;
        clear_monitor();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1'b1);
        check("addr_at_start", cfg_addr, 0);
        check("error_cleared", error, 1'b0);
        n_cyc = 1; guard = 0;
        while (!done && guard < BUDGET) begin
            start = (poke_at > 0 && n_cyc >= poke_at && n_cyc < poke_at + poke_len);
            @(negedge clk);
            guard++;
            if (busy) n_cyc++;
        end
        check("done_seen", done, 1'b1);
        start = poke_done;
        @(negedge clk);
        start = 1'b0;
        check("busy_fall", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        repeat (3) @(negedge clk);
        check("no_restart", busy, 1'b0);
    endtask

    task automatic check_run(input int n_cyc, input bit exact_time);
        check("byte_count", rx_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++)
            check($sformatf("byte%0d", i), rx_bytes[i], exp_bytes[i]);
        check("error", error, exp_err);
        check("addr_end", cfg_addr, exp_addr);
        check("start_count", n_start, exp_txn);
        check("stop_count", n_stop, exp_txn);
        if (exact_time) check("cycles", n_cyc, exp_cyc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mon_clr = 1'b0;
        nack_txn = -1; nack_byte = 0; stretch_len = 0;
        tbl[0] = 16'h4110; tbl[1] = 16'h9803; tbl[2] = 16'hFF00; tbl[3] = 16'hFF00;
        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_addr", cfg_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // two writes, trailing zero-length delays
        build_model();
        run_seq(0, 0, 1'b0, cyc);
        check_run(cyc, 1'b1);

        // NACK on the register byte of entry 0
        tbl[2] = 16'h1234; nack_txn = 0; nack_byte = 1;
        build_model();
        run_seq(0, 0, 1'b0, cyc);
        check_run(cyc, 1'b1);

        // delay entry between two writes
        tbl[1] = 16'hFF02; tbl[2] = 16'h9803; tbl[3] = 16'hFF00; nack_txn = -1;
        build_model();
        run_seq(0, 0, 1'b0, cyc);
        check_run(cyc, 1'b1);

        // slave stretches SCL in bit 3 of byte 1
        tbl[1] = 16'h9803; tbl[2] = 16'hFF00; stretch_len = 37;
        build_model();
        run_seq(0, 0, 1'b0, cyc);
        check_run(cyc, 1'b0);
        check("stretch_cycles", (cyc >= exp_cyc + stretch_len - 3 * CD) && (cyc <= exp_cyc + stretch_len), 1'b1);
        stretch_len = 0;

        // reset during bit 4 of the address byte (bit value 0, SCL low)
        clear_monitor();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (83) @(negedge clk);
        check("mid_scl_low", scl_oe, 1'b1);
        check("mid_sda_low", sda_oe, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_scl_oe", scl_oe, 1'b0);
        check("arst_sda_oe", sda_oe, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk) rst = 1'b0;
        build_model();
        run_seq(0, 0, 1'b0, cyc);
        check_run(cyc, 1'b1);

        // start held high while busy, then coincident with done
        build_model();
        run_seq(10, 300, 1'b1, cyc);
        check_run(cyc, 1'b1);

        for (int r = 0; r < 12; r++) begin
            int p_at, p_len;
            bit p_done;
            for (int e = 0; e < NE; e++) begin
                if ($urandom_range(0, 4) == 0)
                    tbl[e] = {8'hFF, 8'($urandom_range(0, 3))};
                else
                    tbl[e] = {8'($urandom_range(0, 254)), 8'($urandom)};
            end
            if ($urandom_range(0, 2) == 0) begin
                nack_txn = $urandom_range(0, 3); nack_byte = $urandom_range(0, 2);
            end else begin
                nack_txn = -1;
            end
            p_at   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 400) : 0;
            p_len  = $urandom_range(1, 30);
            p_done = 1'($urandom_range(0, 1));
            build_model();
            run_seq(p_at, p_len, p_done, cyc);
            check_run(cyc, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
